// File: rtl/arith_arbiter_pkg.sv
// arith_arb_pkg: shared widths, FSM encoding and operand record for arith_arbiter
package arith_arb_pkg;
  localparam int DATA_W = 16;
  localparam int OP_W = 3;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic cin;
    logic id;
  } opnd_t;
endpackage

// File: rtl/arith_arbiter_if.sv
// arith_arbiter_if: two requester channels plus the shared response bus
interface arith_arbiter_if;
  import arith_arb_pkg::*;
  logic r0_req_valid, r1_req_valid;
  logic r0_req_ready, r1_req_ready;
  logic [OP_W-1:0] r0_op, r1_op;
  logic [DATA_W-1:0] r0_a, r0_b, r1_a, r1_b;
  logic r0_use_carry, r1_use_carry;
  logic r0_rsp_valid, r1_rsp_valid;
  logic r0_rsp_ready, r1_rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic rsp_carry, rsp_compare, busy;
  modport slave (
    input r0_req_valid, r1_req_valid, r0_op, r1_op, r0_a, r0_b, r1_a, r1_b,
    input r0_use_carry, r1_use_carry, r0_rsp_ready, r1_rsp_ready,
    output r0_req_ready, r1_req_ready, r0_rsp_valid, r1_rsp_valid,
    output rsp_result, rsp_carry, rsp_compare, busy
  );
  modport master (
    output r0_req_valid, r1_req_valid, r0_op, r1_op, r0_a, r0_b, r1_a, r1_b,
    output r0_use_carry, r1_use_carry, r0_rsp_ready, r1_rsp_ready,
    input r0_req_ready, r1_req_ready, r0_rsp_valid, r1_rsp_valid,
    input rsp_result, rsp_carry, rsp_compare, busy
  );
endinterface

// File: rtl/arith_arbiter_arithmetic.sv
// Arithmetic: 16-bit datapath; op 0 pass a, 1 a-b-cin (carry=borrow), 2 a+b+cin, 3 and, 4 or, 5 xor, 6 not a, 7 a+1
module Arithmetic
  import arith_arb_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] alu_out,
  output logic              carry_out,
  output logic              compare
);
  logic [DATA_W:0] res, ea, eb, ec;
  assign ea = {1'b0, a};
  assign eb = {1'b0, b};
  assign ec = {{DATA_W{1'b0}}, cin};
  always_comb begin
    res = '0;
    case (op)
      3'd0: res = ea;
      3'd1: res = ea - eb - ec;
      3'd2: res = ea + eb + ec;
      3'd3: res = ea & eb;
      3'd4: res = ea | eb;
      3'd5: res = ea ^ eb;
      3'd6: res = {1'b0, ~a};
      default: res = ea + (DATA_W+1)'(1);
    endcase
  end
  assign alu_out = res[DATA_W-1:0];
  assign carry_out = res[DATA_W];
  assign compare = a == b;
endmodule

// File: rtl/arith_arbiter.sv
// arith_arbiter: round-robin two-requester sequencer around the shared Arithmetic unit
module arith_arbiter
  import arith_arb_pkg::*;
#(
  parameter int FIRST_PRIORITY = 0
) (
  input logic clk,
  input logic rst_n,
  arith_arbiter_if.slave bus
);
  state_t state, state_nx;
  opnd_t opnd;
  logic last_grant, grant, any_req, take_rsp;
  logic [1:0] flag;
  logic [DATA_W-1:0] alu_out, rsp_result;
  logic carry_out, compare, rsp_carry, rsp_compare;

  Arithmetic u_arith (
    .op(opnd.op),
    .a(opnd.a),
    .b(opnd.b),
    .cin(opnd.cin),
    .alu_out(alu_out),
    .carry_out(carry_out),
    .compare(compare)
  );

  always_comb begin
    any_req = bus.r0_req_valid | bus.r1_req_valid;
    grant = (bus.r0_req_valid & bus.r1_req_valid) ? ~last_grant : bus.r1_req_valid;
    take_rsp = opnd.id ? bus.r1_rsp_ready : bus.r0_rsp_ready;
    state_nx = state == IDLE ? (any_req ? EXEC : IDLE) :
               state == EXEC ? RESP :
               (state == RESP && !take_rsp) ? RESP : IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      opnd <= '0;
      last_grant <= FIRST_PRIORITY == 0;
      flag <= '0;
      rsp_result <= '0;
      rsp_carry <= 1'b0;
      rsp_compare <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && any_req) begin
        opnd <= '{op: grant ? bus.r1_op : bus.r0_op,
                  a: grant ? bus.r1_a : bus.r0_a,
                  b: grant ? bus.r1_b : bus.r0_b,
                  cin: flag[grant] & (grant ? bus.r1_use_carry : bus.r0_use_carry),
                  id: grant};
        last_grant <= grant;
      end
      if (state == EXEC) begin
        rsp_result <= alu_out;
        rsp_carry <= carry_out;
        rsp_compare <= compare;
        flag[opnd.id] <= carry_out;
      end
    end
  end

  // ready is gated by rst_n so every output reads 0 while reset is held
  assign bus.r0_req_ready = rst_n && state == IDLE && any_req && !grant;
  assign bus.r1_req_ready = rst_n && state == IDLE && any_req && grant;
  assign bus.r0_rsp_valid = state == RESP && !opnd.id;
  assign bus.r1_rsp_valid = state == RESP && opnd.id;
  assign bus.rsp_result = rsp_result;
  assign bus.rsp_carry = rsp_carry;
  assign bus.rsp_compare = rsp_compare;
  assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_arith_arbiter.sv
// tb_arith_arbiter: directed plan plus random traffic against a behavioural arbiter/ALU model
module tb_arith_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  arith_arbiter_if bus();
  arith_arbiter #(.FIRST_PRIORITY(0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic v[2], uc[2], rr[2];
  logic [2:0] op[2];
  logic [15:0] a[2], b[2];
  logic flag_m[2];
  int last_m, g;
  int n_cmp = 0, n_err = 0;
  logic [17:0] obs;

  assign bus.r0_req_valid = v[0];
  assign bus.r1_req_valid = v[1];
  assign bus.r0_op = op[0];
  assign bus.r1_op = op[1];
  assign bus.r0_a = a[0];
  assign bus.r1_a = a[1];
  assign bus.r0_b = b[0];
  assign bus.r1_b = b[1];
  assign bus.r0_use_carry = uc[0];
  assign bus.r1_use_carry = uc[1];
  assign bus.r0_rsp_ready = rr[0];
  assign bus.r1_rsp_ready = rr[1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] alu_ref(input logic [2:0] o, input logic [15:0] x, y, input logic ci);
    int s;
    logic [15:0] r;
    logic c;
    s = 0; c = 1'b0; r = '0;
    case (o)
      3'd0: r = x;
      3'd1: begin s = int'(x) - int'(y) - int'(ci); r = 16'(s); c = s < 0; end
      3'd2: begin s = int'(x) + int'(y) + int'(ci); r = 16'(s); c = s > 65535; end
      3'd3: r = x & y;
      3'd4: r = x | y;
      3'd5: r = x ^ y;
      3'd6: r = ~x;
      default: begin s = int'(x) + 1; r = 16'(s); c = s > 65535; end
    endcase
    return {x == y, c, r};
  endfunction

  task automatic rnd(input int i);
    op[i] = 3'($urandom);
    a[i] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
    b[i] = ($urandom_range(0, 3) == 0) ? a[i] : 16'($urandom);
    uc[i] = 1'($urandom);
  endtask

  task automatic set_req(input int i, input logic [2:0] o, input logic [15:0] x, y, input logic u);
    v[i] = 1'b1; op[i] = o; a[i] = x; b[i] = y; uc[i] = u;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_rsp_valid", {bus.r1_rsp_valid, bus.r0_rsp_valid}, 0);
    chk("rst_result", bus.rsp_result, 0);
    chk("rst_flags", {bus.rsp_carry, bus.rsp_compare}, 0);
    chk("rst_req_ready", {bus.r1_req_ready, bus.r0_req_ready}, 0);
    flag_m = '{1'b0, 1'b0};
    last_m = 1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // called at a negedge with state IDLE and at least one request presented
  task automatic txn(input int hold, input bit keep, output int g_o, output logic [17:0] obs_o);
    int n, eg, o;
    logic [17:0] e;
    n = 0;
    #1;
    while (!(bus.r0_req_ready || bus.r1_req_ready)) begin
      if (++n > 8) begin
        chk("ready_timeout", bus.r0_req_ready | bus.r1_req_ready, 1);
        g_o = -1; obs_o = '0;
        return;
      end
      @(negedge clk); #1;
    end
    chk("ready_excl", bus.r0_req_ready & bus.r1_req_ready, 0);
    eg = (v[0] && v[1]) ? 1 - last_m : (v[1] ? 1 : 0);
    g_o = bus.r1_req_ready ? 1 : 0;
    chk("grant", g_o, eg);
    o = 1 - eg;
    e = alu_ref(op[eg], a[eg], b[eg], flag_m[eg] & uc[eg]);
    flag_m[eg] = e[16];
    last_m = eg;
    @(negedge clk);
    chk("exec_busy", bus.busy, 1);
    chk("exec_rsp_valid", {bus.r1_rsp_valid, bus.r0_rsp_valid}, 0);
    if (keep) rnd(eg); else v[eg] = 1'b0;
    rr[eg] = hold == 0;
    rr[o] = 1'($urandom);
    @(negedge clk);
    chk("rsp_valid", {bus.r1_rsp_valid, bus.r0_rsp_valid}, eg ? 2 : 1);
    chk("rsp_result", bus.rsp_result, e[15:0]);
    chk("rsp_carry", bus.rsp_carry, e[16]);
    chk("rsp_compare", bus.rsp_compare, e[17]);
    obs_o = {bus.rsp_compare, bus.rsp_carry, bus.rsp_result};
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_state", {bus.busy, bus.r1_req_ready, bus.r0_req_ready, bus.r1_rsp_valid, bus.r0_rsp_valid},
          eg ? 5'b10010 : 5'b10001);
      chk("hold_data", {bus.rsp_compare, bus.rsp_carry, bus.rsp_result}, e);
    end
    rr[eg] = 1'b1;
    @(negedge clk);
    chk("back_idle", bus.busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    v = '{1'b0, 1'b0}; uc = '{1'b0, 1'b0}; rr = '{1'b1, 1'b1};
    op = '{3'd0, 3'd0}; a = '{16'h0, 16'h0}; b = '{16'h0, 16'h0};
    do_reset();
    set_req(0, 3'd2, 16'hFFFF, 16'h0001, 1'b0);
    txn(0, 0, g, obs);
    chk("add_result", obs[15:0], 16'h0000);
    chk("add_carry", obs[16], 1);
    set_req(0, 3'd2, 16'h0000, 16'h0000, 1'b1);
    txn(0, 0, g, obs);
    chk("chain_r0", obs[16:0], 17'h00001);
    set_req(1, 3'd2, 16'h0000, 16'h0000, 1'b1);
    txn(0, 0, g, obs);
    chk("chain_r1", obs[15:0], 16'h0000);
    set_req(1, 3'd7, 16'h1234, 16'h1234, 1'b0);
    txn(0, 0, g, obs);
    chk("inc_cmp", {obs[17], obs[15:0]}, 17'h11235);
    do_reset();
    v = '{1'b1, 1'b1}; rnd(0); rnd(1);
    for (int k = 0; k < 6; k++) begin
      txn(0, 1, g, obs);
      chk("rr_order", g, k % 2);
    end
    v = '{1'b1, 1'b1};
    txn(5, 0, g, obs);
    txn(0, 0, g, obs);
    set_req(0, 3'd2, 16'hFFFF, 16'h0001, 1'b0);
    rr[0] = 1'b0;
    @(negedge clk);
    v[0] = 1'b0;
    @(negedge clk);
    chk("pre_rst_rsp", {bus.r0_rsp_valid, bus.rsp_carry}, 2'b11);
    do_reset();
    rr[0] = 1'b1;
    set_req(0, 3'd2, 16'h0000, 16'h0000, 1'b1);
    txn(0, 0, g, obs);
    chk("post_rst_chain", obs[16:0], 17'h00000);
    for (int it = 0; it < 300; it++) begin
      for (int i = 0; i < 2; i++) begin
        if (v[i] && $urandom_range(0, 3) == 0) v[i] = 1'b0;
        else if (!v[i] && $urandom_range(0, 1) == 1) begin v[i] = 1'b1; rnd(i); end
      end
      if (!v[0] && !v[1]) begin v[0] = 1'b1; rnd(0); end
      txn(($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, 1'($urandom), g, obs);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
